spi_rom_arbiter: RTL and testbench
==================================

SPI_ROM_ARBITER -- requirements
Module: spi_rom_arbiter

Interface
REQ-001 Parameter CS_GAP, default 2: minimum clk cycles spi_cs stays low between transactions (range 1..15).
REQ-002 Parameter DATA_BYTES_MAX, default 16: maximum burst length in bytes.
REQ-003 clk  input  1  sole clock; spi_sclk is derived from it.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1 each  read request from port 0 (video line fetch) and port 1 (auxiliary loader); held high until that port's done pulse.
REQ-006 addr0 / addr1  input  24 each  byte address in ROM; sampled only on the grant cycle.
REQ-007 len0 / len1  input  4 each  burst length minus one, so 0..15 encodes 1..16 bytes; sampled only on the grant cycle.
REQ-008 gnt0 / gnt1  output  1 each  one-cycle pulse when that port's request is accepted.
REQ-009 done0 / done1  output  1 each  one-cycle pulse in the cycle after that port's last byte is delivered.
REQ-010 rd_data  output  8  received byte, MSB first on the wire.
REQ-011 rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-012 rd_port  output  1  owner of the current rd_data (0 or 1); valid while rd_valid is high.
REQ-013 busy  output  1  high from the grant cycle through the end of the CS_GAP.
REQ-014 spi_cs  output  1  flash select, active HIGH, as on the board.
REQ-015 spi_sclk  output  1  ~clk, continuous.
REQ-016 spi_mosi  output  1  command/address bits, registered on posedge clk.
REQ-017 spi_miso  input  1  flash data.

Function
REQ-018 FSM states: IDLE, CMD (8 cycles), ADDR (24 cycles), [DUMMY (8 cycles), only with the macro in REQ-032], DATA (8*(len+1) cycles), GAP (CS_GAP cycles), then IDLE.
REQ-019 In IDLE, any pending request is granted with fixed priority: port 0 beats port 1; simultaneous requests grant port 0.
REQ-020 The grant cycle pulses gnt, latches addr/len/port, and enters CMD on the next cycle.
REQ-021 spi_cs is high for exactly the CMD, ADDR, DUMMY and DATA cycles, and low otherwise.
REQ-022 spi_mosi carries the command MSB first during CMD, then addr[23:0] MSB first during ADDR; it is 0 in every other state.
REQ-023 Bit timing: spi_mosi changes on posedge clk, so the flash samples it on the spi_sclk rise mid-cycle.
REQ-024 Data bit j (j = 0 is the MSB of byte 0) is captured from spi_miso at posedge clk ending DATA cycle j.
REQ-025 After each 8th captured bit, rd_data/rd_valid/rd_port are registered on the following cycle; latency is 1 clk after the byte's last bit.
REQ-026 A request arriving or changing during a transaction or GAP is not sampled; it is arbitrated only in IDLE.
REQ-027 A port-1 request pending while GAP elapses loses to a port-0 request present in the same IDLE cycle.
REQ-028 If a port deasserts its req after gnt, the transaction still runs to completion and done still pulses.
REQ-029 The bit and byte counters wrap correctly for len = 15, giving 128 data bits with no extra spi_cs cycle.

Reset
REQ-030 Reset values: FSM = IDLE; spi_cs = 0, spi_mosi = 0; gnt*, done*, rd_valid, busy = 0; rd_data = 0, rd_port = 0.
REQ-031 A reset asserted mid-transaction drops spi_cs on the next posedge clk, and no done pulse is emitted for the aborted transfer.

Configuration
REQ-032 Macro SPI_FAST_READ_EN: when defined, the block issues command 0Bh and inserts the 8-cycle DUMMY state (MOSI = 0) before DATA; when undefined, it issues command 03h with no DUMMY state.

Structure
REQ-033 The shared package holds the command constants (03h, 0Bh), the CMD/ADDR/DUMMY cycle counts and the FSM state encoding.
REQ-034 One sub-module, spi_rx_shifter, performs the MISO 8-bit shift and byte-valid generation.

Verification
REQ-035 req0 with addr0 = 000120h, len0 = 1 -> MOSI stream 03h,00h,01h,20h; spi_cs high for 48 cycles; 2 rd_valid strobes; done0 pulses once.
REQ-036 req0 and req1 rise in the same cycle -> gnt0 first; gnt1 follows exactly CS_GAP+1 cycles after spi_cs falls.
REQ-037 Flash model returns A5h,3Ch on len = 1 -> rd_data = A5h then 3Ch, rd_port matching the granted port.
REQ-038 len = 15 -> 16 rd_valid strobes; spi_cs high for exactly 160 cycles (168 cycles with SPI_FAST_READ_EN, command 0Bh).
REQ-039 Reset asserted in cycle 20 of ADDR -> spi_cs = 0 after the next edge; no done pulse; a new req0 is then granted cleanly.

Source files
------------

// File: rtl/spi_rom_arbiter_pkg.sv
// spi_rom_arbiter_pkg
//   Shared definitions for the SPI ROM arbiter: flash read command bytes,
//   per-phase cycle counts and the transaction FSM state encoding.
//   Used by spi_rom_arbiter and spi_rx_shifter.
package spi_rom_arbiter_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int unsigned CMD_CYCLES   = 8;
    localparam int unsigned ADDR_CYCLES  = 24;
    localparam int unsigned DUMMY_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

endpackage

// File: rtl/spi_rom_arbiter_rx_shifter.sv
// spi_rx_shifter
//   Shifts spi_miso in MSB first while enabled and emits each completed
//   byte one clk after its last bit, tagged with the owning port.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     en           high during DATA cycles; bit sampled at the edge ending the cycle
//     miso         serial data from the flash
//     tag          port owning the current transfer
//     data         last completed byte (held until the next one)
//     valid        one-cycle strobe qualifying data
//     data_tag     port that owns data
module spi_rx_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       miso,
    input  logic       tag,
    output logic [7:0] data,
    output logic       valid,
    output logic       data_tag
);
    import spi_rom_arbiter_pkg::*;

    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data      <= '0;
            valid     <= 1'b0;
            data_tag  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (en) begin
                shift_q   <= {shift_q[5:0], miso};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    data     <= {shift_q, miso};
                    valid    <= 1'b1;
                    data_tag <= tag;
                end
            end else begin
                bit_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/spi_rom_arbiter.sv
// spi_rom_arbiter
//   Two-port fixed-priority arbiter in front of a SPI NOR flash. Each granted
//   request issues a read command, a 24-bit address and clocks in
//   len+1 bytes, then holds spi_cs low for CS_GAP cycles.
//   Optional macro SPI_FAST_READ_EN: issue 0Bh with 8 dummy cycles instead of 03h.
//   Parameters:
//     CS_GAP          minimum clk cycles spi_cs stays low between transactions (1..15)
//     DATA_BYTES_MAX  maximum burst length in bytes (longer requests are clamped)
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     req0/req1             read requests (port 0 has priority)
//     addr0/addr1, len0/len1  byte address and length-1, sampled in the grant cycle
//     gnt0/gnt1             one-cycle grant pulses
//     done0/done1           one-cycle pulse the cycle after the last byte is delivered
//     rd_data/rd_valid/rd_port  received byte, strobe and owning port
//     busy                  high from the grant cycle through the end of the gap
//     spi_cs (active high), spi_sclk (~clk), spi_mosi, spi_miso  flash pins
module spi_rom_arbiter #(
    parameter int unsigned CS_GAP         = 2,
    parameter int unsigned DATA_BYTES_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [3:0]  len0,
    input  logic [3:0]  len1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_port,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    import spi_rom_arbiter_pkg::*;

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] READ_CMD   = CMD_FAST_READ;
    localparam logic [6:0] DUMMY_LAST = 7'(DUMMY_CYCLES - 1);
`else
    localparam logic [7:0] READ_CMD   = CMD_READ;
`endif
    localparam logic [6:0] CMD_LAST  = 7'(CMD_CYCLES - 1);
    localparam logic [6:0] ADDR_LAST = 7'(ADDR_CYCLES - 1);
    localparam logic [6:0] GAP_LAST  = 7'(CS_GAP - 1);
    localparam logic [3:0] LEN_MAX   = 4'(DATA_BYTES_MAX - 1);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        port_q;
    logic [3:0]  len_q;
    logic [31:0] mosi_sh_q;
    logic        done_pend_q;
    logic        issue0, issue1, start, last_bit;
    logic [23:0] sel_addr;
    logic [3:0]  sel_len;

    assign spi_sclk = ~clk;
    assign sel_addr = port_q ? addr1 : addr0;
    assign sel_len  = port_q ? len1  : len0;
    assign busy     = gnt0 | gnt1 | (state_q != ST_IDLE);

    // gnt is registered, so the grant cycle is a second IDLE cycle with gnt
    // high; addr/len are latched at its closing edge and CMD follows.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 7'd1;
        issue0   = 1'b0;
        issue1   = 1'b0;
        start    = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (gnt0 || gnt1) begin
                    start   = 1'b1;
                    state_d = ST_CMD;
                end else if (req0) begin
                    issue0 = 1'b1;
                end else if (req1) begin
                    issue1 = 1'b1;
                end
            end
            ST_CMD: begin
                if (cnt_q == CMD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
`ifdef SPI_FAST_READ_EN
                    state_d = ST_DUMMY;
`else
                    state_d = ST_DATA;
`endif
                end
            end
`ifdef SPI_FAST_READ_EN
            ST_DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                // 8*(len+1) cycles: the last one has index {len, 3'b111}
                if (cnt_q == {len_q, 3'b111}) begin
                    cnt_d    = '0;
                    last_bit = 1'b1;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            done_pend_q <= 1'b0;
            port_q      <= 1'b0;
            len_q       <= '0;
            mosi_sh_q   <= '0;
            spi_cs      <= 1'b0;
            spi_mosi    <= 1'b0;
        end else begin
            gnt0 <= issue0;
            gnt1 <= issue1;
            if (issue0 || issue1) begin
                port_q <= issue1;
            end
            // shifter register holds the bits still to be sent after the
            // one currently on spi_mosi
            if (start) begin
                len_q     <= (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
                spi_mosi  <= READ_CMD[7];
                mosi_sh_q <= {READ_CMD[6:0], sel_addr, 1'b0};
            end else if (state_d == ST_CMD || state_d == ST_ADDR) begin
                spi_mosi  <= mosi_sh_q[31];
                mosi_sh_q <= {mosi_sh_q[30:0], 1'b0};
            end else begin
                spi_mosi <= 1'b0;
            end
            spi_cs      <= (state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA});
            // last byte appears on rd_valid one cycle after last_bit; done follows it
            done_pend_q <= last_bit;
            done0       <= done_pend_q && !port_q;
            done1       <= done_pend_q &&  port_q;
        end
    end

    spi_rx_shifter u_rx (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == ST_DATA),
        .miso     (spi_miso),
        .tag      (port_q),
        .data     (rd_data),
        .valid    (rd_valid),
        .data_tag (rd_port)
    );

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// tb_spi_rom_arbiter
//   Directed bench for spi_rom_arbiter with a behavioural flash model that
//   captures MOSI and returns a fixed byte pattern on MISO.
module tb_spi_rom_arbiter;

    localparam int unsigned CS_GAP = 2;
`ifdef SPI_FAST_READ_EN
    localparam int         HDR     = 40;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int         HDR     = 32;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [23:0] addr0, addr1;
    logic [3:0]  len0, len1;
    logic        gnt0, gnt1, done0, done1;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_port, busy;
    logic        spi_cs, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;

    always #5 clk = ~clk;

    spi_rom_arbiter #(.CS_GAP(CS_GAP), .DATA_BYTES_MAX(16)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_port(rd_port), .busy(busy),
        .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    function automatic logic [7:0] resp_byte(input int b);
        if (b == 0) return 8'hA5;
        if (b == 1) return 8'h3C;
        return 8'(8'h40 + 8'(b * 7));
    endfunction

    // ---------------- flash model / monitor ----------------
    int          cyc = 0;
    int          k = 0;
    logic [31:0] mosi_cap = '0;
    int          mosi_bad = 0;
    int          last_cs_len = 0;
    int          cs_fall_cyc = 0;
    int          last_rd_cyc = 0;
    int          done0_cyc = 0;
    logic        cs_prev = 1'b0;
    logic [7:0]  rd_log[$];
    logic        rd_port_log[$];
    int          done0_n = 0, done1_n = 0, gnt0_n = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        int j;
        logic [7:0] b;
        if (spi_cs) begin
            if (k < 32) mosi_cap = {mosi_cap[30:0], spi_mosi};
            else if (spi_mosi !== 1'b0) mosi_bad = mosi_bad + 1;
            if (k >= HDR) begin
                j = k - HDR;
                b = resp_byte(j / 8);
                spi_miso = b[7 - (j % 8)];
            end else begin
                spi_miso = 1'b0;
            end
            k = k + 1;
        end else begin
            if (spi_mosi !== 1'b0) mosi_bad = mosi_bad + 1;
            if (cs_prev) begin
                last_cs_len = k;
                cs_fall_cyc = cyc;
            end
            k = 0;
            spi_miso = 1'b0;
        end
        cs_prev = spi_cs;
        if (rd_valid) begin
            rd_log.push_back(rd_data);
            rd_port_log.push_back(rd_port);
            last_rd_cyc = cyc;
        end
        if (done0) begin done0_n = done0_n + 1; done0_cyc = cyc; end
        if (done1) done1_n = done1_n + 1;
        if (gnt0) gnt0_n = gnt0_n + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic port);
        int n = 0;
        do begin
            tick();
            n = n + 1;
        end while (!(port ? gnt1 : gnt0) && n < 20);
        chk(port ? "gnt1_wait" : "gnt0_wait", 32'(port ? gnt1 : gnt0), 32'd1);
    endtask

    task automatic wait_done(input logic port);
        int n = 0;
        do begin
            tick();
            n = n + 1;
        end while (!(port ? done1 : done0) && n < 400);
        chk(port ? "done1_wait" : "done0_wait", 32'(port ? done1 : done0), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n = n + 1;
        end
        chk("idle_wait", 32'(busy), 32'd0);
        tick();
        tick();
    endtask

    task automatic clear_logs();
        rd_log.delete();
        rd_port_log.delete();
        done0_n = 0;
        done1_n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int gap, bad, g0snap;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0;
        len0 = '0; len1 = '0;
        tick(); tick();
        req0 = 1'b1;
        tick(); tick();
        chk("rst_ctrl", 32'({gnt0, gnt1, done0, done1, rd_valid, busy}), 32'd0);
        chk("rst_spi", 32'({spi_cs, spi_mosi}), 32'd0);
        chk("rst_rd", 32'({rd_port, rd_data}), 32'd0);
        req0 = 1'b0;
        reset = 1'b0;
        tick();

        // single port-0 read, 2 bytes
        clear_logs();
        addr0 = 24'h000120; len0 = 4'd1; req0 = 1'b1;
        wait_gnt(1'b0);
        chk("t1_gnt1_quiet", 32'(gnt1), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done(1'b0);
        req0 = 1'b0;
        wait_idle();
        chk("t1_mosi", mosi_cap, {EXP_CMD, 24'h000120});
        chk("t1_cs_len", 32'(last_cs_len), 32'(HDR + 16));
        chk("t1_nbytes", 32'(rd_log.size()), 32'd2);
        chk("t1_data", 32'({rd_log[0], rd_log[1]}), 32'h0000A53C);
        chk("t1_ports", 32'({rd_port_log[0], rd_port_log[1]}), 32'd0);
        chk("t1_done_n", 32'(done0_n), 32'd1);
        chk("t1_rd_latency", 32'(last_rd_cyc - cs_fall_cyc), 32'd0);
        chk("t1_done_after_rd", 32'(done0_cyc - last_rd_cyc), 32'd1);
        chk("t1_mosi_zero", 32'(mosi_bad), 32'd0);

        // simultaneous requests: port 0 first, port 1 after the gap
        clear_logs();
        addr0 = 24'h000200; len0 = 4'd0;
        addr1 = 24'h000300; len1 = 4'd1;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(1'b0);
        chk("t2_gnt1_low", 32'(gnt1), 32'd0);
        wait_done(1'b0);
        req0 = 1'b0;
        wait_gnt(1'b1);
        gap = cyc - cs_fall_cyc;
        chk("t2_gnt1_gap", 32'(gap), 32'(CS_GAP + 1));
        wait_done(1'b1);
        req1 = 1'b0;
        wait_idle();
        chk("t2_nbytes", 32'(rd_log.size()), 32'd3);
        chk("t2_data", 32'({rd_log[0], rd_log[1], rd_log[2]}), 32'h00A5A53C);
        chk("t2_ports", 32'({rd_port_log[0], rd_port_log[1], rd_port_log[2]}), 32'b011);
        chk("t2_mosi", mosi_cap, {EXP_CMD, 24'h000300});
        chk("t2_dones", 32'({done0_n[7:0], done1_n[7:0]}), 32'h0101);

        // request arriving mid-transaction waits; in IDLE port 0 beats pending port 1
        clear_logs();
        addr1 = 24'h000400; len1 = 4'd0; req1 = 1'b1;
        wait_gnt(1'b1);
        tick(); tick(); tick();
        g0snap = gnt0_n;
        addr0 = 24'h000500; len0 = 4'd0; req0 = 1'b1;
        wait_done(1'b1);
        chk("t3_no_midgrant", 32'(gnt0_n), 32'(g0snap));
        addr1 = 24'h000600;
        wait_gnt(1'b0);
        chk("t3_p1_loses", 32'(gnt1), 32'd0);
        wait_done(1'b0);
        req0 = 1'b0;
        wait_gnt(1'b1);
        wait_done(1'b1);
        req1 = 1'b0;
        wait_idle();
        chk("t3_mosi", mosi_cap, {EXP_CMD, 24'h000600});
        chk("t3_ports", 32'({rd_port_log[0], rd_port_log[1], rd_port_log[2]}), 32'b101);

        // maximum burst, 16 bytes
        clear_logs();
        addr1 = 24'h123456; len1 = 4'd15; req1 = 1'b1;
        wait_gnt(1'b1);
        wait_done(1'b1);
        req1 = 1'b0;
        wait_idle();
        chk("t4_nbytes", 32'(rd_log.size()), 32'd16);
        chk("t4_cs_len", 32'(last_cs_len), 32'(HDR + 128));
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < rd_log.size()) begin
                if (rd_log[i] !== resp_byte(i) || rd_port_log[i] !== 1'b1) bad = bad + 1;
            end
        end
        chk("t4_bytes", 32'(bad), 32'd0);
        chk("t4_mosi", mosi_cap, {EXP_CMD, 24'h123456});

        // req dropped right after grant: transfer still completes
        clear_logs();
        addr0 = 24'h00ABCD; len0 = 4'd2; req0 = 1'b1;
        wait_gnt(1'b0);
        req0 = 1'b0;
        wait_done(1'b0);
        wait_idle();
        chk("t5_nbytes", 32'(rd_log.size()), 32'd3);
        chk("t5_done_n", 32'(done0_n), 32'd1);

        // reset in ADDR cycle 20 aborts; a new request then runs cleanly
        clear_logs();
        addr0 = 24'h0FEDCB; len0 = 4'd3; req0 = 1'b1;
        wait_gnt(1'b0);
        for (int i = 0; i < 29; i++) tick();
        chk("t6_pre_cs", 32'(spi_cs), 32'd1);
        reset = 1'b1;
        req0 = 1'b0;
        tick();
        chk("t6_cs_drop", 32'(spi_cs), 32'd0);
        chk("t6_busy_drop", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_done", 32'(done0_n), 32'd0);
        chk("t6_no_bytes", 32'(rd_log.size()), 32'd0);
        addr0 = 24'h000120; len0 = 4'd1; req0 = 1'b1;
        wait_gnt(1'b0);
        wait_done(1'b0);
        req0 = 1'b0;
        wait_idle();
        chk("t6_mosi", mosi_cap, {EXP_CMD, 24'h000120});
        chk("t6_cs_len", 32'(last_cs_len), 32'(HDR + 16));
        chk("t6_data", 32'({rd_log[0], rd_log[1]}), 32'h0000A53C);
        chk("t6_done_n", 32'(done0_n), 32'd1);
        chk("t6_mosi_zero", 32'(mosi_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
